// File: rtl/core_pkg.sv
// core_pkg: shared RV32I pipeline types and constants.
// Holds IF/ID and ID/EX bundles, reset PC and NOP encoding.
package core_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry {instr, pc} buffer for a response caught by a stall.
// Ports: clk, rst, push/pop/clear, in_instr/in_pc in; full, instr, pc out.
module fetch_skid
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= 32'd0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage; PC, imem request FSM, IF/ID register.
// Ports: stall/flush/redirect in, imem req/rsp channel, out/out_valid to decode.
module if_stage
  import core_pkg::if_id_t, core_pkg::word_align;
#(
  parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pcsrc_e,
  input  logic [31:0] pctarget_e,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output if_id_t      out,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state;
  state_e      state_n;
  logic [31:0] pc_f;
  logic [31:0] pc_inflight;
  logic [31:0] target;
  logic        discard;
  logic        kill;
  logic        rsp_fire;
  logic        rsp_good;
  logic        accept;
  logic        skid_full;
  logic        skid_push;
  logic        skid_pop;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  assign target   = word_align(pctarget_e);
  assign kill     = flush_d | pcsrc_e;
  assign rsp_fire = (state == S_WAIT) & imem_rsp_valid;
  assign rsp_good = rsp_fire & ~discard;
  assign accept   = imem_req_valid & imem_req_ready;

  // a response caught by a stall parks in the skid
  assign skid_push = rsp_good & stall_f & ~kill;
  assign skid_pop  = skid_full & ~stall_f & ~kill;

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (skid_push),
    .pop      (skid_pop),
    .clear    (kill),
    .in_instr (imem_rsp_data),
    .in_pc    (pc_inflight),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  always_comb begin
    state_n        = state;
    imem_req_valid = 1'b0;
    imem_addr      = pc_f;
    unique case (state)
      S_BOOT: state_n = S_REQ;
      S_REQ: begin
        imem_req_valid = ~skid_full;
        // redirect goes straight out so the target is what gets accepted
        if (pcsrc_e) imem_addr = target;
        if (~skid_full & imem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          // back-to-back issue only when this response is consumed now
          imem_req_valid = ~pcsrc_e & ~stall_f & ~skid_full;
          if (imem_req_valid & imem_req_ready) state_n = S_WAIT;
          else state_n = S_REQ;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BOOT;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      pc_inflight <= RESET_PC;
    end else if (accept) begin
      pc_f        <= imem_addr + 32'd4;
      pc_inflight <= imem_addr;
    end else if (pcsrc_e) begin
      pc_f <= target;
    end
  end

  // the response already owed to the old path must be dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             discard <= 1'b0;
    else if (rsp_fire)                   discard <= 1'b0;
    else if (state == S_WAIT && pcsrc_e) discard <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '{instr: NOP_INSTR, pc: 32'd0, pcplus4: 32'd0};
      out_valid <= 1'b0;
    end else if (kill) begin
      out       <= '{instr: NOP_INSTR, pc: 32'd0, pcplus4: 32'd0};
      out_valid <= 1'b0;
    end else if (!stall_f) begin
      if (skid_full) begin
        out.instr   <= skid_instr;
        out.pc      <= skid_pc;
        out.pcplus4 <= skid_pc + 32'd4;
        out_valid   <= 1'b1;
      end else if (rsp_good) begin
        out.instr   <= imem_rsp_data;
        out.pc      <= pc_inflight;
        out.pcplus4 <= pc_inflight + 32'd4;
        out_valid   <= 1'b1;
      end else begin
        out       <= '{instr: NOP_INSTR, pc: 32'd0, pcplus4: 32'd0};
        out_valid <= 1'b0;
      end
    end
  end

endmodule
